// File: rtl/ex_fw_ctrl_gen_pkg.sv
// Shared forwarding types: stage selects, the forwarding bus, tracker entries and the load-use FSM.
// Optional macro FW_WBLATE_EN (see ex_fw_ctrl_gen) does not change these types.
package core;

    localparam int CORE_REG_AW = 5;

    typedef enum logic [1:0] {
        NONE_STAGE   = 2'd0,
        MEM_STAGE    = 2'd1,
        WB_STAGE     = 2'd2,
        WBLATE_STAGE = 2'd3
    } fw_stage_e;

    typedef struct packed {
        fw_stage_e rs1;
        fw_stage_e rs2;
    } fw_cntrl_bus_t;

    typedef struct packed {
        logic                   valid;
        logic [CORE_REG_AW-1:0] rd;
        logic                   we;
        logic                   is_load;
    } fw_trk_entry_t;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } fw_fsm_e;

    // x0 is hard-wired zero, so a write to it can never be a real producer.
    function automatic logic fw_match(fw_trk_entry_t e, logic [CORE_REG_AW-1:0] src, logic use_src);
        return e.valid && e.we && (e.rd == src) && (src != '0) && use_src;
    endfunction

endpackage

// File: rtl/ex_fw_ctrl_gen_src_match.sv
// Per-source producer search over the tracker; the youngest matching producer decides the select.
// With FW_WBLATE_EN undefined a WB-entry hit yields NONE_STAGE (register file is write-through).
module fw_src_match
    import core::*;
(
    input  logic [CORE_REG_AW-1:0] src,
    input  logic                   use_src,
    input  fw_trk_entry_t          trk_ex,
    input  fw_trk_entry_t          trk_mem,
    input  fw_trk_entry_t          trk_wb,
    output fw_stage_e              stage,
    output logic                   load_hit
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = fw_match(trk_ex,  src, use_src);
    assign hit_mem = fw_match(trk_mem, src, use_src);
    assign hit_wb  = fw_match(trk_wb,  src, use_src);

    // Select is named after where the producer will be once this source reaches EX.
    always_comb begin
        stage = NONE_STAGE;
        if (hit_ex) begin
            stage = MEM_STAGE;
        end else if (hit_mem) begin
            stage = WB_STAGE;
        end else if (hit_wb) begin
`ifdef FW_WBLATE_EN
            stage = WBLATE_STAGE;
`else
            stage = NONE_STAGE;
`endif
        end
    end

    assign load_hit = hit_ex && trk_ex.is_load;

endmodule

// File: rtl/ex_fw_ctrl_gen.sv
// Forwarding-select generator and load-use interlock for the EX operand muxes.
// Optional macro FW_WBLATE_EN adds the WBLATE tracker entry and the WBLATE_STAGE select.
module ex_fw_ctrl_gen
    import core::*;
#(
    parameter int REG_AW           = CORE_REG_AW,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_we_i,
    input  logic              id_is_load_i,
    input  logic              adv_i,
    input  logic              flush_i,
    output fw_cntrl_bus_t     fw_cntrl_o,
    output logic              stall_o
);

    localparam logic [1:0] LU_CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

    fw_trk_entry_t trk_ex;
    fw_trk_entry_t trk_mem;
    fw_trk_entry_t trk_wb;
`ifdef FW_WBLATE_EN
    fw_trk_entry_t trk_wblate;
`endif
    fw_trk_entry_t id_entry;
    fw_trk_entry_t ex_live;

    fw_stage_e  sel_rs1;
    fw_stage_e  sel_rs2;
    logic       lu_rs1;
    logic       lu_rs2;
    logic       hazard;
    logic       issue;
    fw_fsm_e    state;
    fw_fsm_e    state_n;
    logic [1:0] cnt;
    logic [1:0] cnt_n;

    fw_src_match u_match_rs1 (
        .src      (id_rs1_i),
        .use_src  (id_use_rs1_i),
        .trk_ex   (trk_ex),
        .trk_mem  (trk_mem),
        .trk_wb   (trk_wb),
        .stage    (sel_rs1),
        .load_hit (lu_rs1)
    );

    fw_src_match u_match_rs2 (
        .src      (id_rs2_i),
        .use_src  (id_use_rs2_i),
        .trk_ex   (trk_ex),
        .trk_mem  (trk_mem),
        .trk_wb   (trk_wb),
        .stage    (sel_rs2),
        .load_hit (lu_rs2)
    );

    assign hazard   = id_valid_i && (lu_rs1 || lu_rs2);
    assign id_entry = '{valid: 1'b1, rd: id_rd_i, we: id_we_i, is_load: id_is_load_i};
    assign issue    = id_valid_i && !stall_o && !flush_i;

    // A flushed EX instruction still walks down the pipe, but as a dead slot.
    always_comb begin
        ex_live = trk_ex;
        if (flush_i) begin
            ex_live.valid = 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall_o = 1'b0;
        if (flush_i) begin
            state_n = RUN;
            cnt_n   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        stall_o = 1'b1;
                        if (adv_i) begin
                            state_n = LU_STALL;
                            cnt_n   = LU_CNT_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    if (cnt != '0) begin
                        stall_o = 1'b1;
                        if (adv_i) begin
                            cnt_n = cnt - 2'd1;
                        end
                    end else if (adv_i) begin
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // ID -> EX boundary: tracker shift and registered forwarding selects.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trk_ex.valid  <= 1'b0;
            trk_mem.valid <= 1'b0;
            trk_wb.valid  <= 1'b0;
`ifdef FW_WBLATE_EN
            trk_wblate.valid <= 1'b0;
`endif
            fw_cntrl_o <= '{rs1: NONE_STAGE, rs2: NONE_STAGE};
            state      <= RUN;
            cnt        <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (adv_i) begin
`ifdef FW_WBLATE_EN
                trk_wblate <= trk_wb;
`endif
                trk_wb     <= trk_mem;
                trk_mem    <= ex_live;
                trk_ex     <= issue ? id_entry : fw_trk_entry_t'('0);
                fw_cntrl_o <= issue ? '{rs1: sel_rs1, rs2: sel_rs2}
                                    : '{rs1: NONE_STAGE, rs2: NONE_STAGE};
            end else if (flush_i) begin
                trk_ex.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_fw_ctrl_gen.sv
// Directed-vector bench for ex_fw_ctrl_gen: one instance with 1 load-use bubble, one with 2.
// Distance-3 expectations follow FW_WBLATE_EN.
module tb_ex_fw_ctrl_gen;
    import core::*;

`ifdef FW_WBLATE_EN
    localparam fw_stage_e D3 = WBLATE_STAGE;
`else
    localparam fw_stage_e D3 = NONE_STAGE;
`endif
    localparam fw_stage_e N = NONE_STAGE;
    localparam fw_stage_e M = MEM_STAGE;
    localparam fw_stage_e W = WB_STAGE;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [4:0]    id_rd;
    logic          id_we;
    logic          id_is_load;
    logic          adv;
    logic          flush;
    fw_cntrl_bus_t fw1;
    fw_cntrl_bus_t fw2;
    logic          stall1;
    logic          stall2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_fw_ctrl_gen #(.REG_AW(5), .LOAD_USE_BUBBLES(1)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd), .id_we_i(id_we),
        .id_is_load_i(id_is_load), .adv_i(adv), .flush_i(flush), .fw_cntrl_o(fw1), .stall_o(stall1)
    );

    ex_fw_ctrl_gen #(.REG_AW(5), .LOAD_USE_BUBBLES(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd), .id_we_i(id_we),
        .id_is_load_i(id_is_load), .adv_i(adv), .flush_i(flush), .fw_cntrl_o(fw2), .stall_o(stall2)
    );

    typedef struct {
        logic       vld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       adv;
        logic       flush;
        logic       es;
        fw_stage_e  e1;
        fw_stage_e  e2;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];

    function automatic vec_t v(logic vld, int rs1, int rs2, logic u1, logic u2, int rd, logic we,
                               logic ld, logic av, logic fl, logic es, fw_stage_e e1, fw_stage_e e2);
        vec_t x;
        x.vld = vld; x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.u1 = u1; x.u2 = u2;
        x.rd = 5'(rd); x.we = we; x.ld = ld; x.adv = av; x.flush = fl;
        x.es = es; x.e1 = e1; x.e2 = e2;
        return x;
    endfunction

    task automatic drive(vec_t x);
        id_valid = x.vld; id_rs1 = x.rs1; id_rs2 = x.rs2; id_use_rs1 = x.u1; id_use_rs2 = x.u2;
        id_rd = x.rd; id_we = x.we; id_is_load = x.ld; adv = x.adv; flush = x.flush;
    endtask

    task automatic chk_stall(string n, logic a, logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s stall_o got %0b want %0b", n, a, e);
        end
    endtask

    task automatic chk_fw(string n, fw_cntrl_bus_t a, fw_stage_e e1, fw_stage_e e2);
        checks++;
        if (a.rs1 !== e1) begin
            errors++;
            $display("FAIL %s rs1 got %s want %s", n, a.rs1.name(), e1.name());
        end
        checks++;
        if (a.rs2 !== e2) begin
            errors++;
            $display("FAIL %s rs2 got %s want %s", n, a.rs2.name(), e2.name());
        end
    endtask

    // Drive at negedge, check combinational stall before the edge, registered select after it.
    task automatic run(vec_t x, string n, bit use2);
        @(negedge clk);
        drive(x);
        #1;
        chk_stall(n, use2 ? stall2 : stall1, x.es);
        @(posedge clk);
        #1;
        chk_fw(n, use2 ? fw2 : fw1, x.e1, x.e2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, N, N));
        repeat (2) @(posedge clk);
        #1;
        chk_stall("reset_stall_a", stall1, 1'b0);
        chk_stall("reset_stall_b", stall2, 1'b0);
        chk_fw("reset_fw_a", fw1, N, N);
        chk_fw("reset_fw_b", fw2, N, N);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, N, N));

        //     vld rs1 rs2 u1 u2 rd  we ld adv fl  stall rs1 rs2
        t1.push_back(v(1,  1,  2, 1, 1,  5, 1, 0, 1, 0, 0, N,  N));  // add x5
        t1.push_back(v(1,  5,  7, 1, 1,  6, 1, 0, 1, 0, 0, M,  N));  // sub x6,x5,x7
        t1.push_back(v(0,  0,  0, 0, 0,  0, 0, 0, 1, 0, 0, N,  N));  // nop
        t1.push_back(v(1,  6,  6, 1, 1,  8, 1, 0, 1, 0, 0, W,  W));  // or x8,x6,x6
        t1.push_back(v(1,  6,  8, 1, 1, 10, 1, 0, 1, 0, 0, D3, M));  // and x10,x6,x8
        t1.push_back(v(1, 10, 10, 1, 0,  0, 1, 0, 1, 0, 0, M,  N));  // addi x0,x10
        t1.push_back(v(1,  0,  0, 1, 1,  1, 1, 0, 1, 0, 0, N,  N));  // add x1,x0,x0
        t1.push_back(v(1,  2,  3, 1, 1,  9, 1, 0, 1, 0, 0, N,  N));  // add x9
        t1.push_back(v(1,  4,  4, 1, 1,  9, 1, 0, 1, 0, 0, N,  N));  // add x9 again
        t1.push_back(v(1,  9, 10, 1, 1, 11, 1, 0, 1, 0, 0, M,  N));  // youngest x9 wins
        t1.push_back(v(1,  2,  0, 1, 0,  3, 1, 1, 1, 0, 0, N,  N));  // lw x3
        t1.push_back(v(1,  3,  1, 1, 1,  4, 1, 0, 1, 0, 1, N,  N));  // add x4,x3,x1 stalls
        t1.push_back(v(1,  3,  1, 1, 1,  4, 1, 0, 1, 0, 0, W,  N));  // issues after bubble
        t1.push_back(v(1,  4,  0, 1, 0,  7, 1, 1, 1, 0, 0, M,  N));  // lw x7,(x4)
        t1.push_back(v(1,  1,  7, 1, 1, 12, 1, 0, 0, 0, 1, M,  N));  // hazard, adv=0: hold
        t1.push_back(v(1,  1,  7, 1, 1, 12, 1, 0, 1, 0, 1, N,  N));  // hazard, bubble
        t1.push_back(v(1,  1,  7, 1, 1, 12, 1, 0, 1, 0, 0, N,  W));
        t1.push_back(v(1,  0,  0, 1, 0,  3, 1, 1, 1, 0, 0, N,  N));  // lw x3,(x0)
        t1.push_back(v(1,  3,  3, 1, 1, 13, 1, 0, 1, 1, 0, N,  N));  // flush beats stall
        t1.push_back(v(1,  3,  0, 1, 1, 14, 1, 0, 1, 0, 0, N,  N));  // killed load not forwarded
        t1.push_back(v(1,  0,  0, 0, 0, 15, 1, 0, 1, 0, 0, N,  N));  // add x15
        t1.push_back(v(1, 15, 15, 1, 1, 18, 1, 0, 1, 1, 0, N,  N));  // flush kills x15 in EX
        t1.push_back(v(1, 15, 14, 1, 1, 20, 1, 0, 1, 0, 0, N,  D3)); // x15 gone, x14 distance 3
        t1.push_back(v(1,  0,  0, 0, 0, 16, 1, 1, 1, 0, 0, N,  N));  // lw x16
        t1.push_back(v(1, 16,  0, 1, 0, 17, 1, 0, 0, 1, 0, N,  N));  // flush with adv=0
        t1.push_back(v(1, 16,  0, 1, 0, 17, 1, 0, 1, 0, 0, N,  N));  // EX was killed: no stall
        t1.push_back(v(1,  0,  0, 0, 0,  0, 1, 1, 1, 0, 0, N,  N));  // lw x0
        t1.push_back(v(1,  0,  0, 1, 1,  1, 1, 0, 1, 0, 0, N,  N));  // x0 never stalls

        t2.push_back(v(1,  0,  0, 0, 0,  3, 1, 1, 1, 0, 0, N,  N));  // lw x3
        t2.push_back(v(1,  3,  1, 1, 1,  4, 1, 0, 1, 0, 1, N,  N));  // stall 1 of 2
        t2.push_back(v(1,  3,  1, 1, 1,  4, 1, 0, 1, 0, 1, N,  N));  // stall 2 of 2
        t2.push_back(v(1,  3,  1, 1, 1,  4, 1, 0, 1, 0, 0, D3, N));
        t2.push_back(v(1,  0,  0, 0, 0,  5, 1, 1, 1, 0, 0, N,  N));  // lw x5
        t2.push_back(v(1,  5,  5, 1, 1,  6, 1, 0, 1, 0, 1, N,  N));  // stall, counter loaded
        t2.push_back(v(1,  5,  5, 1, 1,  6, 1, 0, 0, 1, 0, N,  N));  // flush mid-stall
        t2.push_back(v(1,  5,  5, 1, 1,  6, 1, 0, 1, 0, 0, W,  W));  // back in RUN

        do_reset();

        foreach (t1[i]) run(t1[i], $sformatf("a%0d", i), 1'b0);

        // Reset asserted while a load-use stall is pending clears it.
        run(v(1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 0, N, N), "rst_lw", 1'b0);
        @(negedge clk);
        drive(v(1, 3, 3, 1, 1, 4, 1, 0, 1, 0, 1, N, N));
        #1;
        chk_stall("rst_pre", stall1, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_stall("rst_post", stall1, 1'b0);
        chk_fw("rst_post", fw1, N, N);
        @(negedge clk);
        rst = 1'b0;

        do_reset();

        foreach (t2[i]) run(t2[i], $sformatf("b%0d", i), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
